// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_pkg                                                             |
// | Active-low 7-segment pattern constants, scan FSM states and decoder. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package seg7_pkg;

    // Bit order {a,b,c,d,e,f,g}; a 0 lights the segment.
    localparam logic [6:0] PAT_0     = 7'b0000001;
    localparam logic [6:0] PAT_1     = 7'b1001111;
    localparam logic [6:0] PAT_2     = 7'b0010010;
    localparam logic [6:0] PAT_3     = 7'b0000110;
    localparam logic [6:0] PAT_4     = 7'b1001100;
    localparam logic [6:0] PAT_5     = 7'b0100100;
    localparam logic [6:0] PAT_6     = 7'b0100000;
    localparam logic [6:0] PAT_7     = 7'b0001111;
    localparam logic [6:0] PAT_8     = 7'b0000000;
    localparam logic [6:0] PAT_9     = 7'b0000100;
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Returns {legal, code}; illegal patterns return all zeros.
    function automatic logic [4:0] seg7_decode(input logic [6:0] pat);
        case (pat)
            PAT_0:     return {1'b1, 4'd0};
            PAT_1:     return {1'b1, 4'd1};
            PAT_2:     return {1'b1, 4'd2};
            PAT_3:     return {1'b1, 4'd3};
            PAT_4:     return {1'b1, 4'd4};
            PAT_5:     return {1'b1, 4'd5};
            PAT_6:     return {1'b1, 4'd6};
            PAT_7:     return {1'b1, 4'd7};
            PAT_8:     return {1'b1, 4'd8};
            PAT_9:     return {1'b1, 4'd9};
            PAT_BLANK: return {1'b1, CODE_BLANK};
            default:   return 5'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_pattern_decode                                                  |
// | Combinational active-low segment pattern to BCD/blank code decoder.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       legal,
    output logic [3:0] code
);

    logic [4:0] w_dec;

    assign w_dec = seg7_decode(pattern);
    assign legal = w_dec[4];
    assign code  = w_dec[3:0];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan_reader                                                     |
// | Reads a multiplexed active-low 7-segment display back into BCD.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NDIG    = 4,
    parameter int SETTLE  = 8,
    parameter int CONFIRM = 3,
    parameter int TO_W    = 16
)
(
    input  logic                CLK,
    input  logic                RESETN,
    input  logic [6:0]          SEG,
    input  logic [NDIG-1:0]     DIG,
    output logic [4*NDIG-1:0]   DIGITS,
    output logic [NDIG-1:0]     VALID,
    output logic                ERR,
    output logic                SCAN_ERR
);

    localparam int              IDX_W     = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [7:0]      SETTLE_L  = 8'(SETTLE);
    localparam logic [3:0]      CONFIRM_L = 4'(CONFIRM);
    localparam logic [TO_W-1:0] TO_MAX    = {TO_W{1'b1}};

    function automatic logic [IDX_W-1:0] low_index(input logic [NDIG-1:0] d);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!d[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    logic [6:0]      r_seg_s1, r_seg_s2;
    logic [NDIG-1:0] r_dig_s1, r_dig_s2, r_dig_prev, r_lat;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]      r_cnt, r_stab;
    logic [TO_W-1:0] r_to;
    logic            r_err, r_scan_err;
    state_t          r_state;

    logic [NDIG-1:0] w_dig, w_dig_n;
    logic            w_dig_chg, w_onehot, w_multi, w_to_hit;
    logic            w_legal;
    logic [3:0]      w_code;

    assign w_dig     = r_dig_s2;
    assign w_dig_n   = ~w_dig;
    assign w_dig_chg = (w_dig != r_dig_prev);
    assign w_onehot  = (w_dig_n != '0) && ((w_dig_n & (w_dig_n - 1'b1)) == '0);
    assign w_multi   = (w_dig_n != '0) && !w_onehot;
    assign w_to_hit  = (r_state != ST_SAMPLE) && (r_to == TO_MAX - 1'b1);

    seg7_pattern_decode u_decode (
        .pattern (r_seg_s2),
        .legal   (w_legal),
        .code    (w_code)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_seg_s1   <= '1;
            r_seg_s2   <= '1;
            r_dig_s1   <= '1;
            r_dig_s2   <= '1;
            r_dig_prev <= '1;
            r_lat      <= '1;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_stab     <= '0;
            r_to       <= '0;
            r_err      <= 1'b0;
            r_scan_err <= 1'b0;
            r_state    <= ST_IDLE;
        end else begin
            r_seg_s1   <= SEG;
            r_seg_s2   <= r_seg_s1;
            r_dig_s1   <= DIG;
            r_dig_s2   <= r_dig_s1;
            r_dig_prev <= w_dig;
            r_err      <= (r_state == ST_SAMPLE) && !w_legal;

            // Multi-strobe detection runs beside the FSM on its own stability count.
            r_scan_err <= w_multi && !w_dig_chg && (r_stab == SETTLE_L - 8'd1);
            if (w_dig_chg)
                r_stab <= '0;
            else if (r_stab != SETTLE_L)
                r_stab <= r_stab + 8'd1;

            if (r_state == ST_SAMPLE)
                r_to <= '0;
            else if (r_to != TO_MAX)
                r_to <= r_to + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_dig_chg && w_onehot) begin
                        r_lat   <= w_dig;
                        r_idx   <= low_index(w_dig);
                        r_cnt   <= '0;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_dig != r_lat) begin
                        if (w_onehot) begin
                            r_lat   <= w_dig;
                            r_idx   <= low_index(w_dig);
                            r_cnt   <= '0;
                            r_state <= ST_SETTLE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == SETTLE_L - 8'd1)
                            r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: r_state <= ST_HOLD;
                ST_HOLD: begin
                    // The new DIG value is judged now so back-to-back strobes lose no cycle.
                    if (w_dig != r_lat) begin
                        if (w_onehot) begin
                            r_lat   <= w_dig;
                            r_idx   <= low_index(w_dig);
                            r_cnt   <= '0;
                            r_state <= ST_SETTLE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ERR      = r_err;
    assign SCAN_ERR = r_scan_err;

    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        logic [3:0] r_cand, r_ccnt, r_digit;
        logic       r_vld;
        logic [3:0] w_ccnt_nx;
        logic       w_hit, w_write;

        always_comb begin
            w_hit = (r_state == ST_SAMPLE) && (r_idx == IDX_W'(i));
            if (w_code == r_cand)
                w_ccnt_nx = (r_ccnt == CONFIRM_L) ? r_ccnt : r_ccnt + 4'd1;
            else
                w_ccnt_nx = 4'd1;
            w_write = w_hit && w_legal && (w_ccnt_nx == CONFIRM_L);
        end

        always_ff @(posedge CLK or negedge RESETN) begin
            if (!RESETN) begin
                r_cand  <= '0;
                r_ccnt  <= '0;
                r_digit <= '0;
                r_vld   <= 1'b0;
            end else begin
                if (w_hit) begin
                    r_cand <= w_legal ? w_code : 4'd0;
                    r_ccnt <= w_legal ? w_ccnt_nx : 4'd0;
                end
                // A confirmation beats a same-cycle timeout for its own digit.
                if (w_write) begin
                    r_digit <= w_code;
                    r_vld   <= 1'b1;
                end else if (w_to_hit) begin
                    r_vld   <= 1'b0;
                end
            end
        end

        assign DIGITS[4*i +: 4] = r_digit;
        assign VALID[i]         = r_vld;
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg7_scan_reader                                                  |
// | Scoreboard bench: per-strobe model pushes events, monitor pops them. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_seg7_scan_reader;

    localparam int NDIG    = 4;
    localparam int SETTLE  = 8;
    localparam int CONFIRM = 3;
    localparam int TO_W    = 6;

    localparam int EV_UPD  = 0;
    localparam int EV_ERR  = 1;
    localparam int EV_SCAN = 2;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic [6:0]  SEG = 7'h7F;
    logic [3:0]  DIG = 4'hF;
    logic [15:0] DIGITS;
    logic [3:0]  VALID;
    logic        ERR, SCAN_ERR;

    always #5 CLK = ~CLK;

    seg7_scan_reader #(
        .NDIG(NDIG), .SETTLE(SETTLE), .CONFIRM(CONFIRM), .TO_W(TO_W)
    ) dut (
        .CLK(CLK), .RESETN(RESETN), .SEG(SEG), .DIG(DIG),
        .DIGITS(DIGITS), .VALID(VALID), .ERR(ERR), .SCAN_ERR(SCAN_ERR)
    );

    typedef struct {
        int          kind;
        logic [15:0] digits;
        logic [3:0]  valid;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Index 10 is the blank pattern.
    logic [6:0] pat_tab [11] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b1111111};

    int          m_cand [4];
    int          m_cnt  [4];
    logic [15:0] m_digits;
    logic [3:0]  m_valid;
    logic [6:0]  last_pat [4];

    function automatic int code_of(input logic [6:0] p);
        for (int i = 0; i < 11; i++)
            if (pat_tab[i] == p) return (i == 10) ? 15 : i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cand[i] = 0;
            m_cnt[i]  = 0;
        end
        m_digits = '0;
        m_valid  = '0;
    endtask

    // One strobe of digit k showing pattern p: update the model, queue any visible event.
    task automatic model_apply(input int k, input logic [6:0] p);
        int          c;
        ev_t         e;
        logic [15:0] nd;
        logic [3:0]  nv;
        c = code_of(p);
        if (c < 0) begin
            m_cand[k] = 0;
            m_cnt[k]  = 0;
            e.kind = EV_ERR; e.digits = m_digits; e.valid = m_valid;
            exp_q.push_back(e);
        end else begin
            if (c == m_cand[k]) m_cnt[k] = (m_cnt[k] >= CONFIRM) ? CONFIRM : m_cnt[k] + 1;
            else begin
                m_cand[k] = c;
                m_cnt[k]  = 1;
            end
            if (m_cnt[k] == CONFIRM) begin
                nd = m_digits;
                nd[4*k +: 4] = 4'(c);
                nv = m_valid | (4'b1 << k);
                if (nd != m_digits || nv != m_valid) begin
                    e.kind = EV_UPD; e.digits = nd; e.valid = nv;
                    exp_q.push_back(e);
                end
                m_digits = nd;
                m_valid  = nv;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic take(input int kind, input logic [15:0] d, input logic [3:0] v);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d digits=%h valid=%h, required no event",
                     kind, d, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == EV_UPD && (e.digits !== d || e.valid !== v))) begin
                n_fail++;
                $display("FAIL event: got kind=%0d digits=%h valid=%h, required kind=%0d digits=%h valid=%h",
                         kind, d, v, e.kind, e.digits, e.valid);
            end
        end
    endtask

    logic [19:0] mon_prev = '0;
    always @(negedge CLK) begin
        if (!RESETN) begin
            mon_prev = {DIGITS, VALID};
        end else begin
            if (ERR)      take(EV_ERR, DIGITS, VALID);
            if (SCAN_ERR) take(EV_SCAN, DIGITS, VALID);
            if ({DIGITS, VALID} !== mon_prev) take(EV_UPD, DIGITS, VALID);
            mon_prev = {DIGITS, VALID};
        end
    end

    task automatic strobe(input int k, input logic [6:0] p, input int len, input int gap);
        model_apply(k, p);
        SEG = p;
        DIG = 4'hF & ~(4'b1 << k);
        repeat (len) @(posedge CLK);
        #1;
        if (gap > 0) begin
            DIG = 4'hF;
            repeat (gap) @(posedge CLK);
            #1;
        end
    endtask

    task automatic glitch();
        DIG = 4'b1101;
        repeat (4) @(posedge CLK);
        #1;
        DIG = 4'hF;
        repeat (4) @(posedge CLK);
        #1;
    endtask

    task automatic multi();
        ev_t e;
        e.kind = EV_SCAN; e.digits = m_digits; e.valid = m_valid;
        exp_q.push_back(e);
        DIG = 4'b1100;
        repeat (SETTLE + 4) @(posedge CLK);
        #1;
        DIG = 4'hF;
        repeat (3) @(posedge CLK);
        #1;
    endtask

    initial begin
        int          k, nk, gap, r;
        logic [6:0]  p;
        ev_t         e;
        int          wait_cyc;

        model_reset();
        for (int i = 0; i < 4; i++) last_pat[i] = pat_tab[$urandom_range(0, 10)];

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_digits", 32'(DIGITS), 32'h0);
        chk("reset_valid", 32'(VALID), 32'h0);
        chk("reset_err", 32'(ERR), 32'h0);
        chk("reset_scan_err", 32'(SCAN_ERR), 32'h0);
        RESETN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        // Single digit confirmed on the third strobe.
        repeat (3) strobe(0, 7'b0010010, 20, 4);

        // Full scan 7,0,blank,9 back to back.
        repeat (3) begin
            strobe(0, 7'b0001111, SETTLE + 6, 0);
            strobe(1, 7'b0000001, SETTLE + 6, 0);
            strobe(2, 7'b1111111, SETTLE + 6, 0);
            strobe(3, 7'b0000100, SETTLE + 6, 1);
        end
        repeat (4) @(posedge CLK);
        #1;
        chk("scan_digits", 32'(DIGITS), 32'h9F07);
        chk("scan_valid", 32'(VALID), 32'hF);

        // Change then revert on digit 1.
        strobe(1, 7'b1001100, SETTLE + 6, 2);
        strobe(1, 7'b1001100, SETTLE + 6, 2);
        strobe(1, 7'b0100100, SETTLE + 6, 2);
        repeat (3) strobe(1, 7'b1001100, SETTLE + 6, 2);

        // Illegal pattern on digit 2.
        strobe(2, 7'b1111110, SETTLE + 6, 2);
        chk("illegal_valid2", 32'(VALID[2]), 32'h1);
        chk("illegal_digit2", 32'(DIGITS[11:8]), 32'hF);

        glitch();
        multi();

        // Timeout with no strobes.
        if (m_valid != 0) begin
            e.kind = EV_UPD; e.digits = m_digits; e.valid = 4'h0;
            exp_q.push_back(e);
        end
        m_valid = 4'h0;
        repeat (80) @(posedge CLK);
        #1;
        chk("timeout_valid", 32'(VALID), 32'h0);
        chk("timeout_digits", 32'(DIGITS), 32'(m_digits));

        // Reset asserted mid-SETTLE.
        SEG = 7'b1001111;
        DIG = 4'b1110;
        repeat (5) @(posedge CLK);
        #2;
        RESETN = 1'b0;
        #1;
        chk("midreset_digits", 32'(DIGITS), 32'h0);
        chk("midreset_valid", 32'(VALID), 32'h0);
        chk("midreset_err", 32'(ERR), 32'h0);
        chk("midreset_scan_err", 32'(SCAN_ERR), 32'h0);
        DIG = 4'hF;
        SEG = 7'h7F;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        RESETN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        repeat (3) strobe(0, 7'b1001111, SETTLE + 6, 2);

        // Randomised scanning.
        k = $urandom_range(0, 3);
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                do p = 7'($urandom); while (code_of(p) >= 0);
            end else if (r < 65) begin
                p = last_pat[k];
            end else begin
                p = pat_tab[$urandom_range(0, 10)];
            end
            if (code_of(p) >= 0) last_pat[k] = p;
            nk  = $urandom_range(0, 3);
            gap = (nk == k) ? $urandom_range(1, 3) : $urandom_range(0, 3);
            strobe(k, p, SETTLE + 4 + $urandom_range(0, 8), gap);
            if ($urandom_range(0, 19) == 0) glitch();
            if ($urandom_range(0, 19) == 0) multi();
            k = nk;
        end
        DIG = 4'hF;

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 100) begin
            @(posedge CLK);
            wait_cyc++;
        end
        #1;
        chk("pending_events", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Front end that watches the pins of an external multiplexed, active-low 7-segment display.
- It samples the segment bus during each digit strobe and converts each pattern back to a BCD digit.
- A value is published per digit only after it has been confirmed over several scans.
- It is the receiving end of the segment encoding the team's display drivers produce. It is used for loop-back self-test and for reading legacy instrument displays.

Parameters:
- NDIG, 4: number of multiplexed digits; width of the DIG input.
- SETTLE, 8: cycles a strobe must be stable, after synchronisation, before segments are sampled; range 1..255.
- CONFIRM, 3: consecutive identical samples of one digit required before that digit is updated; range 1..15.
- TO_W, 16: width of the timeout counter. No accepted strobe for 2^TO_W-1 cycles clears all VALID bits.

Ports:
- CLK, in, 1: system clock; all state on the rising edge.
- RESETN, in, 1: asynchronous assert, active-low reset.
- SEG, in, 7: active-low segments. Bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g. Asynchronous to CLK.
- DIG, in, NDIG: active-low digit enables. Bit 0 is the rightmost digit. Asynchronous to CLK.
- DIGITS, out, 4*NDIG: confirmed code per digit. Digit i occupies [4i+3:4i]. Codes are 0-9, or 4'hF for blank.
- VALID, out, NDIG: digit i holds a confirmed code.
- ERR, out, 1: one-cycle pulse when a sampled pattern is not in the code table.
- SCAN_ERR, out, 1: one-cycle pulse when more than one DIG bit is active for at least SETTLE cycles.

Behaviour:
- Reset (async, RESETN=0):
  - DIGITS=0, VALID=0, ERR=0, SCAN_ERR=0.
  - Synchronisers are cleared to inactive (all 1s), counters to 0, FSM to IDLE.
  - Release is synchronous to CLK. Reset mid-scan discards any partial confirmation.
- Input synchronisation: two-flop synchroniser on every SEG and DIG bit. All further logic uses synchronised values only, which adds 2 cycles of input latency.
- Code table (pattern -> code):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4
  - 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9
  - 1111111->F (blank)
  - Any other pattern is an error.
- FSM states: IDLE, SETTLE, SAMPLE, HOLD.
  - IDLE: leave when the synchronised DIG changes and the new value is exactly one-hot-low. Latch index k, clear the settle counter, go to SETTLE.
  - SETTLE: count cycles while DIG equals the latched value. If DIG changes first, return to IDLE with no sample taken. When the counter reaches SETTLE, go to SAMPLE.
  - SAMPLE: one cycle. Decode SEG and apply the confirmation rule below. Go to HOLD.
  - HOLD: wait until DIG differs from the latched value, then return to IDLE. This evaluates the new DIG value in the same cycle, so back-to-back strobes lose no cycle. Exactly one sample is taken per strobe.
- Multi-strobe: DIG with two or more zero bits that stays stable for SETTLE cycles gives one SCAN_ERR pulse per occurrence and no sample. All-ones DIG is idle and raises no error.
- Confirmation, per digit k, with a stored candidate and count:
  - Valid code equal to the candidate: count increments, saturating at CONFIRM.
  - Valid code different from the candidate: candidate is replaced and count is set to 1.
  - When count reaches CONFIRM: DIGITS[k] is written with the candidate and VALID[k] is set on the next cycle.
  - Overall latency: last sample edge + 1 cycle.
  - Illegal pattern: ERR pulses on the cycle after SAMPLE. Candidate and count for k reset to 0. DIGITS[k] and VALID[k] are unchanged.
  - CONFIRM=1: every legal sample updates the output directly.
- Timeout: the counter clears on every SAMPLE and otherwise increments, saturating. On reaching 2^TO_W-1, VALID is cleared to 0 and DIGITS is held. It does not re-clear until a new sample occurs.
- Simultaneous events: a timeout clear and a confirmation in the same cycle resolve with the confirmation winning for its digit.

Decomposition:
- seg7_pkg holds:
  - the 11 pattern constants;
  - CODE_BLANK=4'hF;
  - the FSM state enum;
  - a pattern-to-{legal, code} function shared with the display-driver testbenches.
- seg7_pattern_decode is one combinational sub-module (7-bit pattern in, legal + 4-bit code out), instantiated once.
- The per-digit confirmation registers are a generate loop in the top module.

Test Plan:
- Single digit: DIG=1110 held for 20 cycles, SEG=0010010, repeated 3 strobes with 1111 gaps. DIGITS[3:0]=2 and VALID[0]=1 one cycle after the third SAMPLE, not earlier.
- Full scan: digits 0..3 show 7,0,F-blank,9 for 3 scans. DIGITS=16'h9F07 and VALID=4'hF.
- Change then revert: digit 1 shows 4,4,5,4,4,4. Output stays at the previous value until the sixth sample, then becomes 4. The 5 is never published.
- Illegal pattern: SEG=1111110 on digit 2. ERR pulses exactly once, VALID[2] and DIGITS[11:8] are unchanged, and confirmation restarts.
- Glitch and multi-strobe: DIG=1101 held for 4 cycles (shorter than SETTLE) gives no sample. DIG=1100 held for 10 cycles gives one SCAN_ERR pulse.
- Timeout and reset: with TO_W=6, no strobes for 63 cycles sets VALID=0 while DIGITS is retained. RESETN low mid-SETTLE immediately zeroes all outputs. After release, 3 strobes are needed again to confirm.
